// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath widths and opcode encoding.
// The shifter uses WIDTH, SHAMT_W and the per-stage shift distance helper.
package alu_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_SRA = 4'd7
  } alu_op_e;

  // Stage 0 shifts by the largest power of two, the last stage by 1.
  function automatic int stage_shift(input int stage);
    return 1 << (SHAMT_W - 1 - stage);
  endfunction

endpackage

// File: rtl/sra_stage.sv
// One level of the arithmetic barrel shifter: a 32-bit 2:1 mux that either
// passes x through or shifts it right by SHIFT, filling with the sign bit.
module sra_stage
  import alu_pkg::*;
#(
  parameter int SHIFT = 1
) (
  input  logic             sel,
  input  logic             sign,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = x;
    if (sel) begin
      y = {{SHIFT{sign}}, x[WIDTH-1:SHIFT]};
    end
  end

endmodule

// File: rtl/sra32_reg.sv
// Registered 32-bit arithmetic right shifter for the ALU SRA path:
// five cascaded mux stages (16, 8, 4, 2, 1) feeding an output register.
module sra32_reg
  import alu_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] shiftamt,
  output logic [WIDTH-1:0]   Out
);

  logic [WIDTH-1:0] stage_data [SHAMT_W+1];

  assign stage_data[0] = A;

  // Sign fill always comes from the original operand, not the stage input.
  for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
    sra_stage #(
      .SHIFT(stage_shift(g))
    ) u_stage (
      .sel (shiftamt[SHAMT_W-1-g]),
      .sign(A[WIDTH-1]),
      .x   (stage_data[g]),
      .y   (stage_data[g+1])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      Out <= '0;
    end else begin
      Out <= stage_data[SHAMT_W];
    end
  end

endmodule

// File: tb/tb_sra32_reg.sv
// Directed and random checks of the registered arithmetic right shifter.
module tb_sra32_reg;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [4:0]  shiftamt;
  logic [31:0] Out;

  int tests_run    = 0;
  int tests_failed = 0;

  sra32_reg dut (
    .clock   (clock),
    .reset   (reset),
    .A       (A),
    .shiftamt(shiftamt),
    .Out     (Out)
  );

  always #5 clock = ~clock;

  // Drive on the falling edge, then sample just after the capturing rising edge.
  task automatic apply_stimulus(input logic [31:0] a, input logic [4:0] sh);
    @(negedge clock);
    A        = a;
    shiftamt = sh;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset    = 1'b1;
    A        = 32'hFFFF_FFFF;
    shiftamt = 5'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      tests_run++;
      if (Out !== 32'h0000_0000) begin
        tests_failed++;
        $display("[TB] FAIL reset_cycle%0d: got %h expected 00000000", i, Out);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    apply_stimulus(32'hFFFF_FFFF, 5'd0);
    tests_run++;
    if (Out !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: got %h expected ffffffff", Out);
    end
  endtask

  task automatic test_positive();
    logic [4:0]  shs  [9] = '{5'd0, 5'd1, 5'd5, 5'd10, 5'd15, 5'd20, 5'd25, 5'd30, 5'd31};
    logic [31:0] exps [9] = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(32'h0000_0001, shs[i]);
      tests_run++;
      if (Out !== exps[i]) begin
        tests_failed++;
        $display("[TB] FAIL positive_sh%0d: got %h expected %h", shs[i], Out, exps[i]);
      end
    end
  endtask

  task automatic test_negative();
    logic [31:0] avs  [5] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [4:0]  shs  [5] = '{5'd0, 5'd1, 5'd31, 5'd0, 5'd16};
    logic [31:0] exps [5] = '{32'h8000_0000, 32'hC000_0000, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(avs[i], shs[i]);
      tests_run++;
      if (Out !== exps[i]) begin
        tests_failed++;
        $display("[TB] FAIL negative_%h_sh%0d: got %h expected %h", avs[i], shs[i], Out, exps[i]);
      end
    end
  endtask

  task automatic test_nibble();
    logic [31:0] avs  [7] = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678,
                              32'h1234_5678, 32'h0000_FFFF, 32'h8765_4321};
    logic [4:0]  shs  [7] = '{5'd4, 5'd8, 5'd16, 5'd24, 5'd31, 5'd16, 5'd4};
    logic [31:0] exps [7] = '{32'h0123_4567, 32'h0012_3456, 32'h0000_1234, 32'h0000_0012,
                              32'h0000_0000, 32'h0000_0000, 32'hF876_5432};
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(avs[i], shs[i]);
      tests_run++;
      if (Out !== exps[i]) begin
        tests_failed++;
        $display("[TB] FAIL nibble_%h_sh%0d: got %h expected %h", avs[i], shs[i], Out, exps[i]);
      end
    end
  endtask

  // New operands every cycle; Out must hold the previous result until the edge.
  task automatic test_back_to_back();
    logic [31:0] a;
    logic [4:0]  sh;
    logic [31:0] exp_now;
    logic [31:0] exp_prev;
    exp_prev = 32'h0;
    for (int i = 0; i < 20; i++) begin
      a       = 32'hA5C3_0F81 ^ (32'(i) * 32'h1357_9BDF);
      sh      = 5'((i * 7) % 32);
      exp_now = $signed(a) >>> sh;
      @(negedge clock);
      A        = a;
      shiftamt = sh;
      #1;
      if (i > 0) begin
        tests_run++;
        if (Out !== exp_prev) begin
          tests_failed++;
          $display("[TB] FAIL b2b_hold%0d: got %h expected %h", i, Out, exp_prev);
        end
      end
      @(posedge clock);
      #1;
      tests_run++;
      if (Out !== exp_now) begin
        tests_failed++;
        $display("[TB] FAIL b2b_step%0d: got %h expected %h", i, Out, exp_now);
      end
      exp_prev = exp_now;
    end
    @(negedge clock);
    reset    = 1'b1;
    A        = 32'h8000_0000;
    shiftamt = 5'd1;
    @(posedge clock);
    #1;
    tests_run++;
    if (Out !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_mid_reset: got %h expected 00000000", Out);
    end
    @(negedge clock);
    reset = 1'b0;
    apply_stimulus(32'h8000_0000, 5'd1);
    tests_run++;
    if (Out !== 32'hC000_0000) begin
      tests_failed++;
      $display("[TB] FAIL b2b_after_reset: got %h expected c0000000", Out);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [4:0]  sh;
    logic [31:0] exp_val;
    int          bad = 0;
    for (int i = 0; i < 10000; i++) begin
      a       = $urandom;
      sh      = 5'($urandom_range(0, 31));
      exp_val = $signed(a) >>> sh;
      apply_stimulus(a, sh);
      tests_run++;
      if (Out !== exp_val) begin
        tests_failed++;
        bad++;
        if (bad <= 10) begin
          $display("[TB] FAIL random_%h_sh%0d: got %h expected %h", a, sh, Out, exp_val);
        end
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    A        = 32'h0;
    shiftamt = 5'd0;
    test_reset();
    test_positive();
    test_negative();
    test_nibble();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
